// File: rtl/di_bus_master.sv
// di_bus_master: host-side initiator of the di_* device-interface bus.
// Turns a command handshake plus write/read word streams into di_* register
// transfers towards one terminal. Reports a status word per transfer and
// aborts transfers that stall for too long.
module di_bus_master #(
    parameter int          LEN_W          = 16,
    parameter bit          INC_ADDR       = 1'b1,
    parameter int          TIMEOUT        = 1024,
    parameter logic [15:0] TIMEOUT_STATUS = 16'hFFFE
) (
    input  logic             ifclk,
    input  logic             resetb,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [15:0]      cmd_term,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,

    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,

    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,

    output logic             busy,
    output logic             done,
    output logic [15:0]      done_status,

    output logic [15:0]      di_term_addr,
    output logic [31:0]      di_reg_addr,
    output logic [31:0]      di_len,
    output logic             di_read_mode,
    output logic             di_read_req,
    output logic             di_read,
    output logic             di_write_mode,
    output logic             di_write,
    output logic [31:0]      di_reg_datai,
    input  logic             di_read_rdy,
    input  logic             di_write_rdy,
    input  logic [31:0]      di_reg_datao,
    input  logic [15:0]      di_transfer_status
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             xfer_write;
    logic [LEN_W-1:0] words_left;
    logic [CNT_W-1:0] wait_cnt;

    logic             accept;
    logic             wr_hs;
    logic             rd_issue;
    logic             strobe;
    logic             last_strobe;
    logic             waiting;
    logic             timeout_hit;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    // A word is only taken when the previous strobe has finished, which
    // limits the write word rate to one every two cycles.
    assign wr_ready  = (state == S_WR) && di_write_rdy && !di_write
                       && (words_left != '0);

    // Derive the per-cycle transfer events from state and handshakes
    always_comb begin
        accept      = cmd_valid && (state == S_IDLE);
        wr_hs       = wr_valid && wr_ready;
        rd_issue    = (state == S_RD_WAIT) && di_read_rdy && !rd_valid
                      && !di_read && (words_left != '0);
        strobe      = di_write || di_read;
        last_strobe = strobe && (words_left == '0);
        waiting     = ((state == S_WR) && !wr_hs && !di_write)
                      || ((state == S_RD_WAIT) && !rd_issue && !di_read);
        timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection for the transfer sequence
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (cmd_len == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                state_next = xfer_write ? S_WR : S_RD_REQ;
            end
            S_WR: begin
                if (last_strobe || timeout_hit) begin
                    state_next = S_DONE;
                end
            end
            S_RD_REQ: begin
                state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (di_read) begin
                    state_next = (words_left == '0) ? S_DONE : S_RD_REQ;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Command latch, word counter and the registered di_* address/length
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            xfer_write   <= 1'b0;
            words_left   <= '0;
            di_term_addr <= '0;
            di_reg_addr  <= '0;
            di_len       <= '0;
        end else begin
            if (accept) begin
                xfer_write   <= cmd_write;
                words_left   <= cmd_len;
                di_term_addr <= cmd_term;
                di_reg_addr  <= cmd_addr;
                di_len       <= 32'(cmd_len) << 2;
            end else begin
                if (wr_hs || rd_issue) begin
                    words_left <= words_left - LEN_W'(1);
                end
                if (strobe) begin
                    di_reg_addr <= di_reg_addr + 32'(INC_ADDR);
                end
            end
        end
    end

    // Mode levels, single-cycle strobes and write data register
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            di_write_mode <= 1'b0;
            di_read_mode  <= 1'b0;
            di_write      <= 1'b0;
            di_read       <= 1'b0;
            di_read_req   <= 1'b0;
            di_reg_datai  <= '0;
        end else begin
            if (state_next == S_DONE) begin
                di_write_mode <= 1'b0;
                di_read_mode  <= 1'b0;
            end else if ((state == S_IDLE) && (state_next == S_SETUP)) begin
                di_write_mode <= cmd_write;
                di_read_mode  <= !cmd_write;
            end
            di_write    <= wr_hs;
            di_read     <= rd_issue;
            di_read_req <= (state_next == S_RD_REQ);
            if (wr_hs) begin
                di_reg_datai <= wr_data;
            end
        end
    end

    // One-word read buffer; it outlives the transfer until the host drains it
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (di_read) begin
                rd_valid <= 1'b1;
                rd_data  <= di_reg_datao;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

    // Stall counter, cleared whenever the transfer makes progress
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            wait_cnt <= '0;
        end else if (waiting && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // End-of-transfer pulse and status: OK for empty transfers, the responder
    // status from the final strobe, or the abort code after a stall
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            done        <= 1'b0;
            done_status <= '0;
        end else begin
            done <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                if (state == S_IDLE) begin
                    done_status <= '0;
                end else if (last_strobe) begin
                    done_status <= di_transfer_status;
                end else begin
                    done_status <= TIMEOUT_STATUS;
                end
            end
        end
    end

endmodule
